// File: rtl/reg_file_param_if.sv
// Bus bundle for reg_file_param: read ports, write port and clear-engine status.
// The master side (decode/writeback) drives requests; the slave side is the register file.
interface reg_file_param_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);
  logic [NUM_RD-1:0]        rd_en;
  logic [NUM_RD*ADDR_W-1:0] r_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_valid;
  logic                     reg_wr;
  logic [ADDR_W-1:0]        w_addr;
  logic [DATA_W-1:0]        write_data;
  logic                     busy;
  logic                     wr_drop;

  modport master (
    output rd_en, r_addr, reg_wr, w_addr, write_data,
    input  rd_data, rd_valid, busy, wr_drop
  );

  modport slave (
    input  rd_en, r_addr, reg_wr, w_addr, write_data,
    output rd_data, rd_valid, busy, wr_drop
  );
endinterface

// File: rtl/reg_file_param.sv
// Parametrised register file: registered multi-port reads with write bypass and a
// sequential post-reset clear engine. Define REGFILE_ZERO_R0_EN to hardwire entry 0 to zero.
module reg_file_param #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input logic             CLK,
  input logic             RESET,
  reg_file_param_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {CLEAR, READY} state_t;

  state_t                   r_state;
  logic [ADDR_W-1:0]        r_ptr;
  logic [DATA_W-1:0]        r_mem [DEPTH];
  logic [NUM_RD*DATA_W-1:0] r_rd_data;
  logic [NUM_RD-1:0]        r_rd_valid;
  logic                     r_busy;
  logic                     r_wr_drop;

  logic                     w_wr_eff;
  logic [ADDR_W-1:0]        w_raddr [NUM_RD];
  logic [NUM_RD*DATA_W-1:0] w_rd_next;

  // Next read data per port: disabled ports hold, enabled ports see a same-edge write first.
  always_comb begin
    w_wr_eff = bus.reg_wr && (r_state == READY);
`ifdef REGFILE_ZERO_R0_EN
    if (bus.w_addr == '0) w_wr_eff = 1'b0;
`endif
    w_rd_next = r_rd_data;
    for (int k = 0; k < NUM_RD; k++) begin
      w_raddr[k] = bus.r_addr[k*ADDR_W +: ADDR_W];
      if (bus.rd_en[k]) begin
        if (w_wr_eff && (bus.w_addr == w_raddr[k]))
          w_rd_next[k*DATA_W +: DATA_W] = bus.write_data;
        else
          w_rd_next[k*DATA_W +: DATA_W] = r_mem[w_raddr[k]];
`ifdef REGFILE_ZERO_R0_EN
        if (w_raddr[k] == '0) w_rd_next[k*DATA_W +: DATA_W] = '0;
`endif
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state    <= CLEAR;
      r_ptr      <= '0;
      r_busy     <= 1'b1;
      r_rd_data  <= '0;
      r_rd_valid <= '0;
      r_wr_drop  <= 1'b0;
    end else if (r_state == CLEAR) begin
      r_mem[r_ptr] <= '0;
      r_ptr        <= r_ptr + ADDR_W'(1);
      r_wr_drop    <= bus.reg_wr;
      r_rd_valid   <= '0;
      r_rd_data    <= '0;
      if (r_ptr == ADDR_W'(DEPTH - 1)) begin
        r_state <= READY;
        r_busy  <= 1'b0;
      end
    end else begin
      r_wr_drop  <= 1'b0;
      r_rd_valid <= bus.rd_en;
      r_rd_data  <= w_rd_next;
      if (w_wr_eff) r_mem[bus.w_addr] <= bus.write_data;
    end
  end

  assign bus.rd_data  = r_rd_data;
  assign bus.rd_valid = r_rd_valid;
  assign bus.busy     = r_busy;
  assign bus.wr_drop  = r_wr_drop;
endmodule
